// File: rtl/circuito_exp5.sv
// rtl/circuito_exp5.sv - memory-sequence game round controller with 7-segment debug outputs
// Optional timeout feature enabled by defining TIMEOUT_EN.
module circuito_exp5 (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada,
    output logic       db_timeout,
    output logic       db_meio
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] jogada_q, jogada_d;
    logic       tem_q;
    logic       acertou_q, errou_q, pronto_q, timeout_flag_q;
    logic [3:0] mem_word;
    logic       jogada_feita;
    logic       igual;
    logic       timeout;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        // active-high gfedcba pattern, inverted on return
        case (v)
            4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
        endcase
        return ~seg;
    endfunction

    always_comb begin
        case (addr_q)
            4'h0: mem_word = 4'h1;  4'h1: mem_word = 4'h2;  4'h2: mem_word = 4'h4;  4'h3: mem_word = 4'h8;
            4'h4: mem_word = 4'h4;  4'h5: mem_word = 4'h2;  4'h6: mem_word = 4'h1;  4'h7: mem_word = 4'h1;
            4'h8: mem_word = 4'h2;  4'h9: mem_word = 4'h2;  4'hA: mem_word = 4'h4;  4'hB: mem_word = 4'h4;
            4'hC: mem_word = 4'h8;  4'hD: mem_word = 4'h8;  4'hE: mem_word = 4'h1;  default: mem_word = 4'h4;
        endcase
    end

    assign jogada_feita = (|chaves) & ~tem_q;
    assign igual        = (jogada_q == mem_word);

`ifdef TIMEOUT_EN
    logic [11:0] tmo_q, tmo_d;

    assign timeout = (tmo_q == 12'd2999);
    assign db_meio = (tmo_q >= 12'd1500);

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == PREPARA || state_q == PROXIMO)
            tmo_d = 12'd0;
        else if (state_q == ESPERA)
            tmo_d = tmo_q + 12'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            tmo_q <= 12'd0;
        else
            tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
    assign db_meio = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        jogada_d = jogada_q;
        case (state_q)
            INICIAL:  if (iniciar) state_d = PREPARA;
            PREPARA: begin
                addr_d   = 4'h0;
                jogada_d = 4'h0;
                state_d  = ESPERA;
            end
            // a play in the same cycle as the timeout still counts
            ESPERA: begin
                if (jogada_feita)
                    state_d = REGISTRA;
                else if (timeout)
                    state_d = FIM_TIMEOUT;
            end
            REGISTRA: begin
                jogada_d = chaves;
                state_d  = COMPARA;
            end
            COMPARA: begin
                if (!igual)
                    state_d = FIM_ERRO;
                else if (addr_q == 4'hF)
                    state_d = FIM_ACERTO;
                else
                    state_d = PROXIMO;
            end
            PROXIMO: begin
                addr_d  = addr_q + 4'h1;
                state_d = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar) state_d = PREPARA;
            default:  state_d = INICIAL;
        endcase
    end

    // result flags are registered from the next state so they line up with state_q
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= INICIAL;
            addr_q         <= 4'h0;
            jogada_q       <= 4'h0;
            tem_q          <= 1'b0;
            acertou_q      <= 1'b0;
            errou_q        <= 1'b0;
            pronto_q       <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            jogada_q       <= jogada_d;
            tem_q          <= |chaves;
            acertou_q      <= (state_d == FIM_ACERTO);
            errou_q        <= (state_d == FIM_ERRO) || (state_d == FIM_TIMEOUT);
            pronto_q       <= (state_d == FIM_ACERTO) || (state_d == FIM_ERRO) ||
                              (state_d == FIM_TIMEOUT);
            timeout_flag_q <= (state_d == FIM_TIMEOUT);
        end
    end

    assign acertou        = acertou_q;
    assign errou          = errou_q;
    assign pronto         = pronto_q;
    assign db_timeout     = timeout_flag_q;
    assign leds           = chaves;
    assign db_igual       = igual;
    assign db_contagem    = hex7(addr_q);
    assign db_memoria     = hex7(mem_word);
    assign db_estado      = hex7(state_q);
    assign db_jogadafeita = hex7(jogada_q);
    assign db_clock       = clock;
    assign db_iniciar     = iniciar;
    assign db_tem_jogada  = |chaves;

endmodule

// File: tb/tb_circuito_exp5.sv
// tb/tb_circuito_exp5.sv - directed self-checking bench for circuito_exp5
module tb_circuito_exp5;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       acertou, errou, pronto, db_igual;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;
    logic       db_clock, db_iniciar, db_tem_jogada, db_timeout, db_meio;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] rom_m [16];
    logic       tmo_build;

    circuito_exp5 dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
        .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_clock(db_clock),
        .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada),
        .db_timeout(db_timeout), .db_meio(db_meio)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic flags(input string tag, input logic a, input logic e, input logic p, input logic t);
        chk({tag, "_acertou"}, 16'(acertou), 16'(a));
        chk({tag, "_errou"}, 16'(errou), 16'(e));
        chk({tag, "_pronto"}, 16'(pronto), 16'(p));
        chk({tag, "_timeout"}, 16'(db_timeout), 16'(t));
    endtask

    task automatic play(input logic [3:0] v, input logic exp_igual);
        chaves = v;
        tick(2);
        chk("compara_state", 16'(db_estado), 16'(seg(4'h5)));
        chk("compara_igual", 16'(db_igual), 16'(exp_igual));
        chk("leds", 16'(leds), 16'(v));
        chk("tem_jogada", 16'(db_tem_jogada), 16'h1);
        tick(8);
        chaves = 4'h0;
        tick(10);
    endtask

    task automatic start_round();
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(1);
        chk("start_state", 16'(db_estado), 16'(seg(4'h2)));
        chk("start_addr", 16'(db_contagem), 16'(seg(4'h0)));
        flags("start", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rom_m = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                  4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
`ifdef TIMEOUT_EN
        tmo_build = 1'b1;
`else
        tmo_build = 1'b0;
`endif
        reset = 1'b1; iniciar = 1'b0; chaves = 4'h0;
        #12 reset = 1'b0;
        tick(10);
        chk("reset_state", 16'(db_estado), 16'(seg(4'h0)));
        chk("reset_addr", 16'(db_contagem), 16'(seg(4'h0)));
        chk("reset_meio", 16'(db_meio), 16'h0);
        flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // iniciar held 5 cycles starts one round
        iniciar = 1'b1;
        tick(5);
        iniciar = 1'b0;
        chk("hold_state", 16'(db_estado), 16'(seg(4'h2)));
        chk("hold_addr", 16'(db_contagem), 16'(seg(4'h0)));
        chk("hold_mem", 16'(db_memoria), 16'(seg(4'h1)));
        play(4'h1, 1'b1);
        chk("addr1", 16'(db_contagem), 16'(seg(4'h1)));
        play(4'h2, 1'b1);
        chk("addr2", 16'(db_contagem), 16'(seg(4'h2)));
        play(4'h4, 1'b1);
        chk("addr3", 16'(db_contagem), 16'(seg(4'h3)));
        flags("three_plays", 1'b0, 1'b0, 1'b0, 1'b0);

        // idle wait after three plays (counter ~16 at this point)
        tick(1400);
        chk("meio_early", 16'(db_meio), 16'h0);
        tick(200);
        chk("meio_late", 16'(db_meio), 16'(tmo_build));
        chk("wait_state", 16'(db_estado), 16'(seg(4'h2)));
        tick(1900);
        chk("idle_end_state", 16'(db_estado), 16'(seg(tmo_build ? 4'hD : 4'h2)));
        flags("idle_end", 1'b0, tmo_build, tmo_build, tmo_build);

        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        start_round();
        for (int i = 0; i < 16; i++) play(rom_m[i], 1'b1);
        chk("acerto_state", 16'(db_estado), 16'(seg(4'hA)));
        chk("acerto_addr", 16'(db_contagem), 16'(seg(4'hF)));
        flags("acerto", 1'b1, 1'b0, 1'b1, 1'b0);

        start_round();
        play(4'h2, 1'b0);
        chk("erro_state", 16'(db_estado), 16'(seg(4'hE)));
        chk("erro_jogada", 16'(db_jogadafeita), 16'(seg(4'h2)));
        flags("erro", 1'b0, 1'b1, 1'b1, 1'b0);

        // exact timeout boundaries, counted from the PREPARA edge
        start_round();
        tick(1499);
        chk("meio_1499", 16'(db_meio), 16'h0);
        tick(1);
        chk("meio_1500", 16'(db_meio), 16'(tmo_build));
        tick(1499);
        chk("tmo_2999_state", 16'(db_estado), 16'(seg(4'h2)));
        flags("tmo_2999", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk("tmo_3000_state", 16'(db_estado), 16'(seg(tmo_build ? 4'hD : 4'h2)));
        flags("tmo_3000", 1'b0, tmo_build, tmo_build, tmo_build);

        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(1);
        chk("pre_reset_start", 16'(db_estado), 16'(seg(4'h2)));
        for (int i = 0; i < 5; i++) play(rom_m[i], 1'b1);
        chk("pre_reset_addr", 16'(db_contagem), 16'(seg(4'h5)));
        #2 reset = 1'b1;
        #1;
        chk("async_reset_state", 16'(db_estado), 16'(seg(4'h0)));
        chk("async_reset_addr", 16'(db_contagem), 16'(seg(4'h0)));
        chk("async_reset_jogada", 16'(db_jogadafeita), 16'(seg(4'h0)));
        chk("async_reset_meio", 16'(db_meio), 16'h0);
        flags("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(3);
        chk("post_reset_state", 16'(db_estado), 16'(seg(4'h0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/circuito_exp5.md
CIRCUITO_EXP5 -- requirements
Module: circuito_exp5

Interface
REQ-001 clock  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state.
REQ-003 iniciar  in  1  level start request.
REQ-004 chaves  in  4  player input, one-hot play; 0000 = no play.
REQ-005 acertou, errou, pronto  out  1 each  round result flags.
REQ-006 leds  out  4  SHALL equal chaves combinationally.
REQ-007 db_igual  out  1  registered play equals current memory word.
REQ-008 db_contagem, db_memoria, db_estado, db_jogadafeita  out  7 each  seven-segment digits of address, memory word, state code and registered play.
- Segment order: bits [6:0] = g,f,e,d,c,b,a; active-low.
- Standard hex glyphs 0-F.
REQ-009 db_clock  out  1  equals clock; db_iniciar  out  1  equals iniciar.
REQ-010 db_tem_jogada  out  1  equals |chaves.
REQ-011 db_timeout  out  1  timeout reached; db_meio  out  1  half of the timeout window elapsed.

Function
REQ-012 ROM: 16x4, internal, read combinationally at a 4-bit address counter.
- Addresses 0-F hold: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4.
REQ-013 Play detect: jogada_feita SHALL be a one-cycle pulse on the rising edge of |chaves, using a registered copy of |chaves.
REQ-014 FSM states and db_estado codes:
- INICIAL=0, PREPARA=1, ESPERA=2, REGISTRA=4, COMPARA=5, PROXIMO=6, FIM_ACERTO=A, FIM_ERRO=E, FIM_TIMEOUT=D.
REQ-015 INICIAL: iniciar=1 -> PREPARA, else stay.
REQ-016 PREPARA: clear address counter, play register and timeout counter -> ESPERA (one cycle).
REQ-017 ESPERA:
- jogada_feita -> REGISTRA.
- else timeout -> FIM_TIMEOUT.
- jogada_feita has priority over timeout in the same cycle.
REQ-018 REGISTRA: load chaves into the play register -> COMPARA.
REQ-019 COMPARA:
- mismatch -> FIM_ERRO.
- match at address 15 -> FIM_ACERTO.
- match otherwise -> PROXIMO.
REQ-020 PROXIMO: increment address, clear timeout counter -> ESPERA.
REQ-021 In all three end states, pronto=1.
- FIM_ACERTO: acertou=1.
- FIM_ERRO and FIM_TIMEOUT: errou=1.
- FIM_TIMEOUT: db_timeout=1.
- All flags are held until iniciar=1, which goes to PREPARA.
- acertou, errou and pronto are 0 in every other state.
REQ-022 Timeout counter: 12-bit; increments each cycle in ESPERA; cleared in PREPARA/PROXIMO.
- timeout asserts when count = 2999, i.e. the 3000th waiting cycle.
- db_meio = (count >= 1500).
REQ-023 The address counter SHALL NOT wrap in normal play; address 15 ends the round.
REQ-024 Holding iniciar across several cycles SHALL start exactly one round.
- Plays arriving before ESPERA are not counted, except by edge.

Reset
REQ-025 On reset=1, independent of clock:
- State = INICIAL; address, play register, timeout counter and edge register cleared.
- acertou=errou=pronto=db_timeout=db_meio=0.
REQ-026 Reset mid-round SHALL abort the round; no flags persist.

Configuration
REQ-027 Macro TIMEOUT_EN.
- Defined: REQ-017 and REQ-022 timeout behaviour is present.
- Undefined: no timeout counter; ESPERA waits indefinitely; db_timeout=db_meio=0 constant; FIM_TIMEOUT is unreachable.

Verification
REQ-028 Reset pulse, then idle 10 cycles -> db_estado glyph 0; all result flags 0.
REQ-029 iniciar=1 for 5 cycles, then plays 0001, 0010, 0100, each held 10 cycles with 10 idle cycles between -> db_igual=1 in COMPARA; db_contagem advances 0->1->2->3; no flags.
REQ-030 After those 3 plays, chaves=0000 for 3500 cycles, TIMEOUT_EN defined:
- db_meio=1 after about 1500 cycles.
- FIM_TIMEOUT after 3000 cycles; errou=pronto=db_timeout=1; db_estado glyph D.
REQ-031 All 16 correct plays -> acertou=pronto=1, db_estado A.
- Then iniciar -> flags cleared, address 0.
REQ-032 First play 0010 (expected 0001) -> errou=pronto=1, db_estado E, db_jogadafeita glyph 2.
REQ-033 Reset asserted during ESPERA at address 5 -> immediate INICIAL; address 0; flags 0.
